// File: rtl/dec_scan.sv
// dec_scan: registered active-low one-hot decoder with enable gating, valid/ready load
// and an optional self-timed scan mode, compiled in when DEC_SCAN_EN is defined.
module dec_scan #(
  parameter int unsigned SEL_W     = 3,
  parameter int unsigned DWELL     = 4,
  parameter int unsigned SCAN_LAST = (1 << SEL_W) - 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            en_i,
  input  logic                  mode_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [SEL_W-1:0]      data_i,
  output logic [(2**SEL_W)-1:0] data_o,
  output logic [SEL_W-1:0]      idx_o,
  output logic                  wrap_o
);

  localparam int unsigned OUT_W = 2**SEL_W;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] DIRECT = 2'b01;

  if (SCAN_LAST > OUT_W - 1) begin : g_bad_scan_last
    $error("dec_scan: SCAN_LAST exceeds OUT_W-1");
  end
  if (DWELL < 1) begin : g_bad_dwell
    $error("dec_scan: DWELL must be at least 1");
  end

  function automatic logic [OUT_W-1:0] onehot_n(input logic [SEL_W-1:0] i);
    onehot_n = ~(OUT_W'(1) << i);
  endfunction

  logic [1:0]       state, state_n;
  logic [SEL_W-1:0] idx_n;
  logic [OUT_W-1:0] data_n;
  logic             ready_n;
  logic             wrap_n;
  logic             enabled;
  logic             scan_req;

  assign enabled = (en_i == 3'b100);

`ifdef DEC_SCAN_EN
  localparam logic [1:0]  SCAN = 2'b10;
  localparam int unsigned CW   = $clog2(DWELL) + 1;

  logic [CW-1:0] dwell, dwell_n;

  assign scan_req = mode_i;
`else
  logic unused_cfg;

  // Scan mode absent: mode_i is treated as 0 and the scan parameters are not used.
  assign scan_req   = 1'b0;
  assign unused_cfg = ^{mode_i, 32'(DWELL), 32'(SCAN_LAST)};
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_n = state;
    idx_n   = idx_o;
    data_n  = data_o;
    ready_n = ready_o;
    wrap_n  = 1'b0;
`ifdef DEC_SCAN_EN
    dwell_n = dwell;
`endif
    if (!enabled) begin
      state_n = IDLE;
      data_n  = '1;
      ready_n = 1'b0;
`ifdef DEC_SCAN_EN
      dwell_n = '0;
`endif
    end else begin
      case (state)
        IDLE, DIRECT: begin
          if (scan_req) begin
`ifdef DEC_SCAN_EN
            state_n = SCAN;
            idx_n   = '0;
            data_n  = onehot_n('0);
            ready_n = 1'b0;
            dwell_n = '0;
`endif
          end else begin
            state_n = DIRECT;
            ready_n = 1'b1;
            if (state == IDLE) begin
              data_n = onehot_n(idx_o);
            end else if (valid_i && ready_o) begin
              idx_n  = data_i;
              data_n = onehot_n(data_i);
            end
          end
        end
`ifdef DEC_SCAN_EN
        SCAN: begin
          if (!scan_req) begin
            state_n = DIRECT;
            ready_n = 1'b1;
          end else begin
            ready_n = 1'b0;
            if (dwell == CW'(DWELL - 1)) begin
              dwell_n = '0;
              if (idx_o == SEL_W'(SCAN_LAST)) begin
                idx_n  = '0;
                wrap_n = 1'b1;
              end else begin
                idx_n = idx_o + SEL_W'(1);
              end
              data_n = onehot_n(idx_n);
            end else begin
              dwell_n = dwell + CW'(1);
            end
          end
        end
`endif
        default: begin
          state_n = IDLE;
          data_n  = '1;
          ready_n = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx_o   <= '0;
      data_o  <= '1;
      ready_o <= 1'b0;
      wrap_o  <= 1'b0;
`ifdef DEC_SCAN_EN
      dwell   <= '0;
`endif
    end else begin
      state   <= state_n;
      idx_o   <= idx_n;
      data_o  <= data_n;
      ready_o <= ready_n;
      wrap_o  <= wrap_n;
`ifdef DEC_SCAN_EN
      dwell   <= dwell_n;
`endif
    end
  end

endmodule

// File: doc/dec_scan.md
# dec_scan

Parametrised, registered successor to the team's 3-to-8 enable-gated decoder. It decodes a SEL_W-bit index onto a 2^SEL_W active-low one-hot output, gated by the same three-pin enable pattern. It adds a valid/ready load port and an optional self-timed scan mode that steps through outputs, for digit and row strobing. It sits between control logic and display or bank-select drivers.

## Interface
- SEL_W, 3, index width; OUT_W = 2**SEL_W (localparam)
- DWELL, 4, cycles each index is held in scan mode (≥1)
- SCAN_LAST, OUT_W-1, highest index visited in scan (≤OUT_W-1; elaboration error otherwise)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- en_i  in  3  enable pins; block enabled iff en_i == 3'b100
- mode_i  in  1  0 = direct, 1 = scan (ignored without DEC_SCAN_EN)
- valid_i  in  1  load request for data_i (direct mode)
- ready_o  out  1  load accepted when valid_i & ready_o at an edge
- data_i  in  SEL_W  index to load
- data_o  out  OUT_W  active-low one-hot of idx_o; all ones when disabled
- idx_o  out  SEL_W  current selected index
- wrap_o  out  1  one-cycle pulse when scan wraps to index 0

## Operation
- States: IDLE, DIRECT, SCAN. All outputs are registered and updated on the same edge as the state.
- Reset (asserted): state IDLE, data_o all ones, idx_o 0, ready_o 0, wrap_o 0, dwell counter 0. Takes effect immediately, including mid-scan.
- Any state, en_i != 3'b100 at the edge: go to IDLE; data_o all ones; ready_o 0; dwell counter cleared; idx_o held. Disable wins over a simultaneous valid_i (no load).
- IDLE → DIRECT (enabled, mode_i=0): data_o = ~(1<<idx_o), ready_o 1.
- IDLE → SCAN (enabled, mode_i=1): idx_o 0, dwell counter 0, data_o = ~1.
- DIRECT: ready_o 1. On handshake, idx_o ← data_i and data_o ← ~(1<<data_i). Otherwise the outputs are held. Every data_i value is legal.
- SCAN: ready_o 0; valid_i ignored. Dwell counter counts 0..DWELL-1. At DWELL-1 it clears and idx_o advances.
- SCAN wrap: if idx_o == SCAN_LAST, idx_o ← 0 and wrap_o is 1 for exactly that one cycle.
- DIRECT → SCAN (mode_i 0→1): idx_o restarts at 0, dwell counter cleared.
- SCAN → DIRECT (mode_i 1→0): idx_o and data_o held; ready_o 1 from that edge.
- Dwell counter width: $clog2(DWELL)+1 bits; no overflow for any legal DWELL.

## Timing
- Enable or handshake sampled at edge k → data_o, idx_o and ready_o valid after edge k: one-cycle latency, no combinational path from input to output.
- Scan: each index is visible for exactly DWELL cycles. Full period is (SCAN_LAST+1)·DWELL cycles.
- wrap_o is coincident with the first cycle of index 0 after a wrap. It does not pulse on scan entry.
- ready_o is combinationally independent of valid_i.

## Configuration
- DEC_SCAN_EN defined: SCAN state, dwell counter and wrap_o logic are compiled in; mode_i is honoured.
- DEC_SCAN_EN undefined: mode_i is ignored and treated as 0. The block is DIRECT/IDLE only. wrap_o is tied 0. DWELL and SCAN_LAST are unused.

## Test plan
All scenarios use SEL_W=3, DWELL=4, SCAN_LAST=7 unless noted; DEC_SCAN_EN defined.
- Reset mid-scan: drop rst_n while idx_o=5 → immediately data_o=8'hFF, idx_o=0, ready_o=0, wrap_o=0.
- Direct load: en_i=3'b100, mode_i=0, one-cycle valid_i with data_i=3'b010 → after that edge data_o=8'hFB, idx_o=2. Then en_i=3'b001 → data_o=8'hFF, idx_o stays 2.
- Full scan: en_i=3'b100, mode_i=1 →
  - data_o=8'hFE for 4 cycles, then 8'hFD, …, 8'h7F;
  - at cycle 32 back to 8'hFE with wrap_o=1 for one cycle.
- Partial scan, SCAN_LAST=5: indices 0..5 only; wrap_o every 24 cycles; data_o never 8'hBF or 8'h7F.
- Disable vs valid: en_i→3'b000 with valid_i=1, data_i=7 at the same edge → no load; idx_o unchanged; data_o=8'hFF.
- Mode switch: in SCAN at idx_o=3, set mode_i=0 → data_o=8'hF7 held, ready_o=1. Then load data_i=7 → data_o=8'h7F. With DEC_SCAN_EN undefined, mode_i=1 behaves as direct and wrap_o stays 0.
